// File: rtl/frame_read_streamer.sv
// Frame read streamer: drives the address generator, issues synchronous RAM reads and
// buffers returned words in a first-word-fall-through FIFO behind a valid/ready stream.
module frame_read_streamer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FRAME_LEN  = 20,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              frame_error,
  output logic              gen_enable,
  input  logic [ADDR_W-1:0] gen_address,
  input  logic              gen_last,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned SUM_W  = PTR_W + 2;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              frame_error_q, frame_error_d;
  logic              done_q, done_d;
  logic              v1_q, v2_q, last2_q;
  logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fifo_count_q;
  logic [SUM_W-1:0]  credit_sum;
  logic [DATA_W:0]   head;
  logic              exp_last, push, pop;

  // Reads already in flight count against the FIFO space so a push never overflows.
  assign credit_sum = SUM_W'(fifo_count_q) + SUM_W'(v1_q) + SUM_W'(v2_q);
  assign exp_last   = (rd_cnt_q == LastIdx);
  assign push       = v2_q;
  assign pop        = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    rd_cnt_d      = rd_cnt_q + CNT_W'(v1_q);
    frame_error_d = frame_error_q | (v1_q & (gen_last != exp_last));
    done_d        = 1'b0;
    gen_enable    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StRun;
          issue_cnt_d   = '0;
          rd_cnt_d      = '0;
          frame_error_d = 1'b0;
        end
      end
      StRun: begin
        gen_enable = (credit_sum < SUM_W'(FIFO_DEPTH));
        if (gen_enable) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      issue_cnt_q   <= '0;
      rd_cnt_q      <= '0;
      frame_error_q <= 1'b0;
      done_q        <= 1'b0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      last2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      frame_error_q <= frame_error_d;
      done_q        <= done_d;
      v1_q          <= gen_enable;
      v2_q          <= v1_q;
      last2_q       <= exp_last;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {mem_rd_data, last2_q};
  end

  assign head        = fifo_mem_q[rd_ptr_q];
  assign out_valid   = (fifo_count_q != '0);
  assign out_data    = out_valid ? head[DATA_W:1] : '0;
  assign out_last    = out_valid & head[0];
  assign mem_rd_en   = v1_q;
  assign mem_rd_addr = gen_address;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_frame_read_streamer.sv
// Directed bench for frame_read_streamer with generator and RAM models and a word scoreboard.
module tb_frame_read_streamer;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned FRAME_LEN  = 20;
  localparam int unsigned FIFO_DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, frame_error, gen_enable;
  logic [ADDR_W-1:0] gen_address;
  logic              gen_last;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;

  frame_read_streamer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .frame_error(frame_error),
    .gen_enable (gen_enable),
    .gen_address(gen_address),
    .gen_last   (gen_last),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clock = ~clock;

  // Generator model: registered address/lastData, updated only on enable, wraps at frame end.
  bit fault;
  logic [ADDR_W-1:0] gcnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gcnt        <= '0;
      gen_address <= '0;
      gen_last    <= 1'b0;
    end else if (gen_enable) begin
      gen_address <= gcnt;
      gen_last    <= (gcnt == ADDR_W'(FRAME_LEN - 1)) || (fault && gcnt == 5'd4);
      gcnt        <= (gcnt == ADDR_W'(FRAME_LEN - 1)) ? '0 : gcnt + 1'b1;
    end
  end

  // RAM model: word = address + 0x10, one cycle read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= 8'h10 + {3'b000, mem_rd_addr};
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hold, en_cycles, run, max_run, first_en, first_valid;
  int done_pulses, done_cyc, last_hs_cyc, words, max_fill;
  bit rnd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    en_cycles = 0; run = 0; max_run = 0; first_en = -1; first_valid = -1;
    done_pulses = 0; done_cyc = -1; last_hs_cyc = -1; words = 0; max_fill = 0;
  endtask

  // One clock: drive ready shortly after the edge, then sample settled outputs.
  task automatic step();
    logic [7:0] exp_d;
    @(posedge clock);
    #1;
    cyc++;
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else if (rnd) out_ready = 1'($urandom_range(1, 0));
    else out_ready = 1'b1;
    #1;
    if (gen_enable) begin
      en_cycles++;
      run++;
      if (run > max_run) max_run = run;
      if (first_en < 0) first_en = cyc;
    end else run = 0;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      exp_d = 8'h10 + 8'(words % int'(FRAME_LEN));
      check("word_data", {24'd0, out_data}, {24'd0, exp_d});
      check("word_last", {31'd0, out_last}, {31'd0, (words % int'(FRAME_LEN)) == int'(FRAME_LEN) - 1});
      if (out_last) last_hs_cyc = cyc;
      words++;
    end
    if (done) begin
      done_pulses++;
      done_cyc = cyc;
    end
    if (int'(dut.fifo_count_q) > max_fill) max_fill = int'(dut.fifo_count_q);
  endtask

  task automatic run_until_done(input int budget, input int target);
    int n = 0;
    while (done_pulses < target && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", {31'd0, done_pulses >= target}, 32'd1);
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    int hold;
    bit rnd;
    bit flt;
    bit exp_err;
    int exp_run;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{hold: 0,  rnd: 1'b0, flt: 1'b0, exp_err: 1'b0, exp_run: 20};
    vecs[1] = '{hold: 15, rnd: 1'b0, flt: 1'b0, exp_err: 1'b0, exp_run: 0};
    vecs[2] = '{hold: 0,  rnd: 1'b1, flt: 1'b0, exp_err: 1'b0, exp_run: 0};
    vecs[3] = '{hold: 0,  rnd: 1'b0, flt: 1'b1, exp_err: 1'b1, exp_run: 20};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; fault = 1'b0; hold = 0; rnd = 1'b0;
    clear_obs();
    repeat (2) @(posedge clock);
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_gen_en", {31'd0, gen_enable}, 32'd0);
    check("rst_err", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      clear_obs();
      fault = vecs[i].flt;
      rnd   = vecs[i].rnd;
      hold  = vecs[i].hold;
      start_frame();
      if (vecs[i].hold > 0) begin
        repeat (12) step();
        check($sformatf("v%0d_en_stalled", i), en_cycles, 32'd4);
        check($sformatf("v%0d_gen_en_low", i), {31'd0, gen_enable}, 32'd0);
        check($sformatf("v%0d_head", i), {24'd0, out_data}, 32'h10);
        check($sformatf("v%0d_fill", i), {29'd0, dut.fifo_count_q}, 32'd4);
        check($sformatf("v%0d_no_words", i), words, 32'd0);
      end
      run_until_done(400, 1);
      repeat (2) step();
      check($sformatf("v%0d_en_cycles", i), en_cycles, FRAME_LEN);
      check($sformatf("v%0d_words", i), words, FRAME_LEN);
      check($sformatf("v%0d_done_pulses", i), done_pulses, 32'd1);
      check($sformatf("v%0d_done_after_last", i), done_cyc, last_hs_cyc + 1);
      check($sformatf("v%0d_frame_error", i), {31'd0, frame_error}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_fill_bound", i), {31'd0, max_fill <= int'(FIFO_DEPTH)}, 32'd1);
      if (vecs[i].exp_run > 0) begin
        check($sformatf("v%0d_max_run", i), max_run, vecs[i].exp_run);
        check($sformatf("v%0d_latency", i), first_valid - first_en, 32'd3);
      end
    end

    // A fresh start clears the sticky error left by the faulty frame.
    fault = 1'b0; rnd = 1'b0;
    clear_obs();
    start_frame();
    check("err_cleared_on_start", {31'd0, frame_error}, 32'd0);
    run_until_done(400, 1);
    check("err_clean_frame", {31'd0, frame_error}, 32'd0);
    check("clean_words", words, FRAME_LEN);

    // Asynchronous reset mid-frame, then a complete frame from address 0.
    clear_obs();
    start_frame();
    for (int n = 0; n < 200 && words < 7; n++) step();
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", {24'd0, out_data}, 32'd0);
    check("arst_last", {31'd0, out_last}, 32'd0);
    check("arst_gen_en", {31'd0, gen_enable}, 32'd0);
    check("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("arst_rd_addr", {27'd0, mem_rd_addr}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_fifo_empty", {29'd0, dut.fifo_count_q}, 32'd0);
    #3;
    reset = 1'b0;
    clear_obs();
    start_frame();
    run_until_done(400, 1);
    check("post_rst_words", words, FRAME_LEN);

    // start held high through a frame and its done cycle: exactly one back-to-back frame.
    clear_obs();
    start = 1'b1;
    run_until_done(400, 1);
    step();
    start = 1'b0;
    run_until_done(400, 2);
    repeat (3) step();
    check("b2b_done_pulses", done_pulses, 32'd2);
    check("b2b_words", words, 2 * FRAME_LEN);
    check("b2b_en_cycles", en_cycles, 2 * FRAME_LEN);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
